ex_mem_skid_buf: RTL and testbench
==================================

Name: ex_mem_skid_buf

Overview:
- Parametrised EX→MEM pipeline buffer that replaces the single-entry EX output register.
- Holds up to DEPTH in-flight EX results in a circular buffer with a valid/ready handshake on both sides.
- in_ready is computed from occupancy alone, which breaks the combinational stall path from MEM back to EX.
- Tracks trap-class entries (scall/eret/udf) and can optionally block younger instructions behind them.

Parameters:
- XLEN, 32, datapath width of pc, nextpc, alu_res, op3.
- DEPTH, 2, number of buffer entries; any integer 1..8, not restricted to powers of two.
- TRAP_BLOCK, 1, when 1 no new entry is accepted while a trap-class entry is stored.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all stored entries.
- in_valid  in  1  EX holds a valid result (EX bubble = !in_valid).
- in_ready  out  1  buffer accepts an entry this cycle.
- in_pc, in_nextpc, in_alu_res, in_op3  in  XLEN each  EX results.
- in_cmp_res  in  2  compare result.
- in_ctrl  in  CTRL_W  packed ex_ctrl_t.
- out_valid  out  1  head entry valid.
- out_ready  in  1  MEM consumes the head this cycle.
- out_pc, out_nextpc, out_alu_res, out_op3  out  XLEN each  head payload.
- out_cmp_res  out  2;  out_ctrl  out  CTRL_W  head payload.
- count  out  $clog2(DEPTH+1)  number of stored entries.
- trap_pending  out  1  at least one stored entry has scall, eret or udf set.

Behaviour:
- Storage: DEPTH entries plus head and tail pointers of max(1,$clog2(DEPTH)) bits. Pointers wrap from DEPTH-1 to 0, including for non-power-of-2 DEPTH.
- push = in_valid && in_ready; pop = out_valid && out_ready.
- in_ready = (count != DEPTH) && !(TRAP_BLOCK && trap_pending). in_ready does not depend on out_ready, so a pop in the same cycle never frees a slot for a push while full.
- out_valid = (count != 0). No empty bypass: an entry pushed at edge N appears on out_* after edge N (1-cycle latency).
- Order is strict FIFO; every entry is delivered exactly once.
- out_* payload is forced to 0 whenever out_valid = 0, so outputs are deterministic after reset and flush.
- Push only: write tail, tail+1, count+1. Pop only: head+1, count-1. Push and pop together: both pointers advance, count unchanged.
- trap_pending is a per-entry trap bit OR-reduced over valid entries. It is set on push when in_ctrl.scall|eret|udf and cleared when that entry pops.
- flush has priority over push and pop in the same cycle: count, head and tail go to 0 and all trap bits clear. The in_valid entry in that cycle is dropped and nothing pops (MEM must ignore out_* that cycle). out_valid = 0 from the next cycle.
- Reset, asynchronous and allowed mid-operation: count 0, head/tail 0, trap bits 0. Hence out_valid 0, payload 0, trap_pending 0, in_ready 1. Entry payload RAM is not reset.
- DEPTH = 1 degenerates to a registered stage with full-cycle throughput loss on back-to-back transfers; this is accepted.
- Overflow and underflow are impossible by construction. Assertions: no push when count == DEPTH, no pop when count == 0.

Decomposition:
- Package br32_pipe_pkg holds ex_ctrl_t, a packed struct in this field order: rd[4:0], w_rd, w_cr, link, mem_r, mem_w, mem_sz[1:0], mem_sx, io_r, io_w, mfsr, mtsr, mfcr, res_in_mem, scall, eret, udf.
- CTRL_W = $bits(ex_ctrl_t) = 22.
- Helper function is_trap(ex_ctrl_t) also lives in the package.
- One sub-module, wrap_ctr: a DEPTH-modulo pointer with inc and clr inputs and an async reset. It is instantiated twice, for head and tail.

Test Plan:
- Reset, then push pc=0x100,0x104 with out_ready=0 and DEPTH=2 → count=2, in_ready=0. Raise out_ready → out_pc 0x100 then 0x104, count back to 0, payload 0 afterwards.
- Continuous in_valid=1 and out_ready=1, DEPTH=2, pc stepping by 4 from 0x200 → after 1-cycle latency one output per cycle, in order, count steady at 1.
- DEPTH=3, 7 pushes interleaved with random out_ready → output order matches input order across pointer wrap and count never exceeds 3.
- Push an entry with udf=1, TRAP_BLOCK=1 → trap_pending=1 and in_ready=0 until it pops. Then trap_pending=0 and in_ready=1 on the next cycle.
- count=2, then flush=1 together with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0, trap_pending=0, and the flushed input never appears.
- Assert rst asynchronously mid-cycle with count=2 → outputs go to reset values immediately without waiting for a clock edge, and the first push after release appears at out_pc.

Source files
------------

// File: rtl/ex_mem_skid_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : br32_pipe_pkg
//  Description : Shared pipeline types for the br32 core: the EX-stage control
//                bundle carried into MEM, its width, and a trap-class helper.
//  Contents    : ex_ctrl_t  - packed EX control word (22 bits)
//                CTRL_W     - $bits(ex_ctrl_t)
//                is_trap()  - true for scall / eret / udf entries
//  Revision    : 1.0 - initial release
// ============================================================================
package br32_pipe_pkg;

  typedef struct packed {
    logic [4:0] rd;
    logic       w_rd;
    logic       w_cr;
    logic       link;
    logic       mem_r;
    logic       mem_w;
    logic [1:0] mem_sz;
    logic       mem_sx;
    logic       io_r;
    logic       io_w;
    logic       mfsr;
    logic       mtsr;
    logic       mfcr;
    logic       res_in_mem;
    logic       scall;
    logic       eret;
    logic       udf;
  } ex_ctrl_t;

  localparam int CTRL_W = $bits(ex_ctrl_t);

  function automatic logic is_trap(input ex_ctrl_t c);
    return c.scall | c.eret | c.udf;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mem_skid_buf_wrap_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : wrap_ctr
//  Description : Modulo-DEPTH pointer. Counts 0..DEPTH-1 and wraps to 0, so
//                non-power-of-two depths are handled without an extra compare
//                at the point of use.
//  Ports       : clk    - clock, rising edge
//                rst    - asynchronous active-high reset (pointer -> 0)
//                clr_i  - synchronous clear, has priority over inc_i
//                inc_i  - advance the pointer by one
//                ptr_o  - current pointer value
//  Revision    : 1.0 - initial release
// ============================================================================
module wrap_ctr #(
  parameter int DEPTH = 2,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  localparam logic [W-1:0] C_LAST = W'(DEPTH - 1);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = (ptr_q == C_LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule
`default_nettype wire

// File: rtl/ex_mem_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_skid_buf
//  Description : EX->MEM pipeline buffer. A DEPTH-entry circular FIFO with
//                valid/ready on both sides. in_ready is a function of
//                occupancy only, so MEM back-pressure never reaches EX
//                combinationally. Trap-class entries are tracked and can
//                block younger pushes while stored.
//  Ports       : clk, rst          - clock / async active-high reset
//                flush             - drop every stored entry (sync)
//                in_valid/in_ready - EX-side handshake
//                in_*              - EX payload (pc, nextpc, alu_res, op3,
//                                    cmp_res, ctrl)
//                out_valid/out_ready - MEM-side handshake
//                out_*             - head payload, zero while out_valid = 0
//                count             - number of stored entries
//                trap_pending      - a stored entry is scall/eret/udf
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_skid_buf
  import br32_pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 2,
  parameter int TRAP_BLOCK = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_nextpc,
  input  logic [XLEN-1:0]            in_alu_res,
  input  logic [XLEN-1:0]            in_op3,
  input  logic [1:0]                 in_cmp_res,
  input  ex_ctrl_t                   in_ctrl,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_nextpc,
  output logic [XLEN-1:0]            out_alu_res,
  output logic [XLEN-1:0]            out_op3,
  output logic [1:0]                 out_cmp_res,
  output ex_ctrl_t                   out_ctrl,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       trap_pending
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  // Payload storage; deliberately not reset, out_* are masked instead.
  logic [XLEN-1:0] pc_q      [DEPTH];
  logic [XLEN-1:0] nextpc_q  [DEPTH];
  logic [XLEN-1:0] alu_res_q [DEPTH];
  logic [XLEN-1:0] op3_q     [DEPTH];
  logic [1:0]      cmp_res_q [DEPTH];
  ex_ctrl_t        ctrl_q    [DEPTH];

  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [DEPTH-1:0] trap_q;
  logic [DEPTH-1:0] trap_d;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             push;
  logic             pop;
  logic             push_eff;
  logic             pop_eff;

  // Occupancy-only ready: a same-cycle pop never opens a slot while full.
  assign in_ready  = (count_q != C_FULL) && !((TRAP_BLOCK != 0) && trap_pending);
  assign out_valid = (count_q != '0);

  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  // flush wins: neither side moves in a flush cycle.
  assign push_eff = push && !flush;
  assign pop_eff  = pop && !flush;

  wrap_ctr #(
    .DEPTH (DEPTH),
    .W     (PW)
  ) u_head_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush),
    .inc_i (pop_eff),
    .ptr_o (head)
  );

  wrap_ctr #(
    .DEPTH (DEPTH),
    .W     (PW)
  ) u_tail_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush),
    .inc_i (push_eff),
    .ptr_o (tail)
  );

  always_comb begin
    count_d = count_q;
    trap_d  = trap_q;
    if (flush) begin
      count_d = '0;
      trap_d  = '0;
    end else begin
      if (push_eff && !pop_eff) begin
        count_d = count_q + 1'b1;
      end else if (pop_eff && !push_eff) begin
        count_d = count_q - 1'b1;
      end
      // head != tail whenever both move, so the order of these is free.
      if (pop_eff) begin
        trap_d[head] = 1'b0;
      end
      if (push_eff) begin
        trap_d[tail] = is_trap(in_ctrl);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      trap_q  <= '0;
    end else begin
      count_q <= count_d;
      trap_q  <= trap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) begin
      pc_q[tail]      <= in_pc;
      nextpc_q[tail]  <= in_nextpc;
      alu_res_q[tail] <= in_alu_res;
      op3_q[tail]     <= in_op3;
      cmp_res_q[tail] <= in_cmp_res;
      ctrl_q[tail]    <= in_ctrl;
    end
  end

  assign out_pc       = out_valid ? pc_q[head]      : '0;
  assign out_nextpc   = out_valid ? nextpc_q[head]  : '0;
  assign out_alu_res  = out_valid ? alu_res_q[head] : '0;
  assign out_op3      = out_valid ? op3_q[head]     : '0;
  assign out_cmp_res  = out_valid ? cmp_res_q[head] : '0;
  assign out_ctrl     = out_valid ? ctrl_q[head]    : '0;
  assign count        = count_q;
  assign trap_pending = |trap_q;

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (count_q == C_FULL)));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && (count_q == '0)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_mem_skid_buf
//  Description : Self-checking bench. Two instances: A (DEPTH=2) for the
//                directed scenarios and B (DEPTH=3) for pointer wrap under
//                random back-pressure. Accepted inputs are queued as expected
//                outputs; a negedge monitor pops and compares each delivery.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_skid_buf;
  import br32_pipe_pkg::*;

  localparam int PW_BITS = 32 * 4 + 2 + CTRL_W;

  logic clk;
  logic rst;

  // Instance A
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_trap;
  logic [31:0] a_in_pc, a_in_nextpc, a_in_alu_res, a_in_op3;
  logic [31:0] a_out_pc, a_out_nextpc, a_out_alu_res, a_out_op3;
  logic [1:0]  a_in_cmp, a_out_cmp, a_count;
  ex_ctrl_t    a_in_ctrl, a_out_ctrl;

  // Instance B
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_trap;
  logic [31:0] b_in_pc, b_in_nextpc, b_in_alu_res, b_in_op3;
  logic [31:0] b_out_pc, b_out_nextpc, b_out_alu_res, b_out_op3;
  logic [1:0]  b_in_cmp, b_out_cmp, b_count;
  ex_ctrl_t    b_in_ctrl, b_out_ctrl;

  int checks = 0;
  int errors = 0;
  int b_popped = 0;

  logic [PW_BITS-1:0] qa[$];
  logic [PW_BITS-1:0] qb[$];
  logic [PW_BITS-1:0] exp_a, exp_b;

  ex_mem_skid_buf #(.XLEN(32), .DEPTH(2), .TRAP_BLOCK(1)) u_dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_pc(a_in_pc), .in_nextpc(a_in_nextpc), .in_alu_res(a_in_alu_res), .in_op3(a_in_op3),
    .in_cmp_res(a_in_cmp), .in_ctrl(a_in_ctrl),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_pc(a_out_pc), .out_nextpc(a_out_nextpc), .out_alu_res(a_out_alu_res), .out_op3(a_out_op3),
    .out_cmp_res(a_out_cmp), .out_ctrl(a_out_ctrl),
    .count(a_count), .trap_pending(a_trap)
  );

  ex_mem_skid_buf #(.XLEN(32), .DEPTH(3), .TRAP_BLOCK(1)) u_dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_pc(b_in_pc), .in_nextpc(b_in_nextpc), .in_alu_res(b_in_alu_res), .in_op3(b_in_op3),
    .in_cmp_res(b_in_cmp), .in_ctrl(b_in_ctrl),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_pc(b_out_pc), .out_nextpc(b_out_nextpc), .out_alu_res(b_out_alu_res), .out_op3(b_out_op3),
    .out_cmp_res(b_out_cmp), .out_ctrl(b_out_ctrl),
    .count(b_count), .trap_pending(b_trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Any reset discards the stored entries of both instances.
  always @(posedge rst) begin
    qa.delete();
    qb.delete();
  end

  // Scoreboard A: compare deliveries, then enqueue accepted inputs.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_flush) begin
        qa.delete();
      end else begin
        if (a_out_valid && a_out_ready) begin
          checks++;
          if (qa.size() == 0) begin
            errors++;
            $display("FAIL a_sb_order: got unexpected pc 0x%0h, required no output", a_out_pc);
          end else begin
            exp_a = qa.pop_front();
            if ({a_out_pc, a_out_nextpc, a_out_alu_res, a_out_op3, a_out_cmp, a_out_ctrl} !== exp_a) begin
              errors++;
              $display("FAIL a_sb_payload: got 0x%h required 0x%h",
                       {a_out_pc, a_out_nextpc, a_out_alu_res, a_out_op3, a_out_cmp, a_out_ctrl}, exp_a);
            end
          end
        end
        if (a_in_valid && a_in_ready)
          qa.push_back({a_in_pc, a_in_nextpc, a_in_alu_res, a_in_op3, a_in_cmp, a_in_ctrl});
      end
    end
  end

  // Scoreboard B
  always @(negedge clk) begin
    if (!rst) begin
      if (b_out_valid && b_out_ready) begin
        checks++;
        b_popped++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL b_sb_order: got unexpected pc 0x%0h, required no output", b_out_pc);
        end else begin
          exp_b = qb.pop_front();
          if ({b_out_pc, b_out_nextpc, b_out_alu_res, b_out_op3, b_out_cmp, b_out_ctrl} !== exp_b) begin
            errors++;
            $display("FAIL b_sb_payload: got 0x%h required 0x%h",
                     {b_out_pc, b_out_nextpc, b_out_alu_res, b_out_op3, b_out_cmp, b_out_ctrl}, exp_b);
          end
        end
      end
      if (b_in_valid && b_in_ready)
        qb.push_back({b_in_pc, b_in_nextpc, b_in_alu_res, b_in_op3, b_in_cmp, b_in_ctrl});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic ex_ctrl_t mk_ctrl(input logic [31:0] pc, input logic sc, input logic er, input logic ud);
    ex_ctrl_t c;
    c        = '0;
    c.rd     = pc[6:2];
    c.w_rd   = pc[2];
    c.mem_sz = pc[4:3];
    c.scall  = sc;
    c.eret   = er;
    c.udf    = ud;
    return c;
  endfunction

  task automatic drive_a(input logic v, input logic [31:0] pc, input ex_ctrl_t c);
    a_in_valid   = v;
    a_in_pc      = pc;
    a_in_nextpc  = pc + 32'd4;
    a_in_alu_res = ~pc;
    a_in_op3     = {pc[15:0], pc[31:16]};
    a_in_cmp     = pc[3:2];
    a_in_ctrl    = c;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] pc);
    b_in_valid   = v;
    b_in_pc      = pc;
    b_in_nextpc  = pc + 32'd4;
    b_in_alu_res = pc ^ 32'h5A5A_0000;
    b_in_op3     = pc << 1;
    b_in_cmp     = pc[3:2];
    b_in_ctrl    = mk_ctrl(pc, 1'b0, 1'b0, 1'b0);
  endtask

  int  idx;
  int  cyc;
  logic acc;

  initial begin
    rst = 1'b1;
    a_flush = 1'b0; a_out_ready = 1'b0;
    b_flush = 1'b0; b_out_ready = 1'b0;
    drive_a(1'b0, 32'h0, '0);
    drive_b(1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_count", 32'(a_count), 32'd0);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_trap", 32'(a_trap), 32'd0);
    chk("rst_out_pc", a_out_pc, 32'd0);

    // Fill to DEPTH, then drain
    drive_a(1'b1, 32'h100, mk_ctrl(32'h100, 0, 0, 0));
    tick();
    drive_a(1'b1, 32'h104, mk_ctrl(32'h104, 0, 0, 0));
    tick();
    drive_a(1'b0, 32'h0, '0);
    chk("fill_count", 32'(a_count), 32'd2);
    chk("fill_in_ready", 32'(a_in_ready), 32'd0);
    chk("fill_out_pc", a_out_pc, 32'h100);
    a_out_ready = 1'b1;
    #1;
    chk("full_ready_indep", 32'(a_in_ready), 32'd0);
    tick();
    chk("drain_out_pc1", a_out_pc, 32'h104);
    chk("drain_count1", 32'(a_count), 32'd1);
    tick();
    chk("drain_count0", 32'(a_count), 32'd0);
    chk("drain_out_valid", 32'(a_out_valid), 32'd0);
    chk("drain_pc_zero", a_out_pc, 32'd0);
    chk("drain_alu_zero", a_out_alu_res, 32'd0);
    chk("drain_ctrl_zero", 32'(a_out_ctrl), 32'd0);

    // Streaming: one transfer per cycle, count steady at 1
    for (int k = 0; k < 8; k++) begin
      drive_a(1'b1, 32'h200 + 32'(4 * k), mk_ctrl(32'h200 + 32'(4 * k), 0, 0, 0));
      tick();
      chk("stream_count", 32'(a_count), 32'd1);
      chk("stream_out_pc", a_out_pc, 32'h200 + 32'(4 * k));
    end
    drive_a(1'b0, 32'h0, '0);
    tick();
    chk("stream_end_count", 32'(a_count), 32'd0);

    // Trap blocking
    a_out_ready = 1'b0;
    drive_a(1'b1, 32'h300, mk_ctrl(32'h300, 0, 0, 1));
    tick();
    drive_a(1'b1, 32'h304, mk_ctrl(32'h304, 0, 0, 0));
    chk("trap_pending", 32'(a_trap), 32'd1);
    chk("trap_in_ready", 32'(a_in_ready), 32'd0);
    chk("trap_count", 32'(a_count), 32'd1);
    tick();
    chk("trap_block_count", 32'(a_count), 32'd1);
    a_out_ready = 1'b1;
    tick();
    chk("trap_clear", 32'(a_trap), 32'd0);
    chk("trap_ready_back", 32'(a_in_ready), 32'd1);
    chk("trap_pop_count", 32'(a_count), 32'd0);
    tick();
    chk("trap_next_count", 32'(a_count), 32'd1);
    chk("trap_next_pc", a_out_pc, 32'h304);
    drive_a(1'b0, 32'h0, '0);
    tick();
    chk("trap_drain", 32'(a_count), 32'd0);

    // Flush with simultaneous push and pop
    a_out_ready = 1'b0;
    drive_a(1'b1, 32'h400, mk_ctrl(32'h400, 0, 0, 0));
    tick();
    drive_a(1'b1, 32'h404, mk_ctrl(32'h404, 1, 0, 0));
    tick();
    chk("pre_flush_count", 32'(a_count), 32'd2);
    chk("pre_flush_trap", 32'(a_trap), 32'd1);
    a_flush = 1'b1;
    a_out_ready = 1'b1;
    drive_a(1'b1, 32'h4F0, mk_ctrl(32'h4F0, 0, 0, 0));
    tick();
    a_flush = 1'b0;
    drive_a(1'b0, 32'h0, '0);
    chk("flush_count", 32'(a_count), 32'd0);
    chk("flush_out_valid", 32'(a_out_valid), 32'd0);
    chk("flush_trap", 32'(a_trap), 32'd0);
    chk("flush_out_pc", a_out_pc, 32'd0);
    tick();
    chk("flush_dropped", 32'(a_count), 32'd0);
    a_out_ready = 1'b0;

    // Asynchronous reset mid-cycle
    drive_a(1'b1, 32'h500, mk_ctrl(32'h500, 0, 0, 0));
    tick();
    drive_a(1'b1, 32'h504, mk_ctrl(32'h504, 0, 1, 0));
    tick();
    drive_a(1'b0, 32'h0, '0);
    chk("pre_arst_count", 32'(a_count), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 32'(a_count), 32'd0);
    chk("arst_out_valid", 32'(a_out_valid), 32'd0);
    chk("arst_out_pc", a_out_pc, 32'd0);
    chk("arst_in_ready", 32'(a_in_ready), 32'd1);
    chk("arst_trap", 32'(a_trap), 32'd0);
    rst = 1'b0;
    tick();
    drive_a(1'b1, 32'h508, mk_ctrl(32'h508, 0, 0, 0));
    tick();
    drive_a(1'b0, 32'h0, '0);
    chk("post_arst_count", 32'(a_count), 32'd1);
    chk("post_arst_pc", a_out_pc, 32'h508);
    a_out_ready = 1'b1;
    tick();
    chk("post_arst_drain", 32'(a_count), 32'd0);
    a_out_ready = 1'b0;

    // DEPTH=3: 7 pushes under random back-pressure, across pointer wrap
    idx = 0;
    cyc = 0;
    while ((idx < 7 || b_count != 2'd0) && cyc < 300) begin
      drive_b(idx < 7, 32'h600 + 32'(4 * idx));
      b_out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = b_in_valid && b_in_ready;
      chk("b_count_max", 32'(b_count <= 2'd3 && b_count != 2'd3 || b_count == 2'd3), 32'd1);
      if (b_count == 2'd3) chk("b_full_ready", 32'(b_in_ready), 32'd0);
      @(posedge clk);
      #1;
      if (acc) idx++;
      cyc++;
    end
    drive_b(1'b0, 32'h0);
    b_out_ready = 1'b0;
    chk("b_no_timeout", 32'(cyc < 300), 32'd1);
    chk("b_popped", 32'(b_popped), 32'd7);
    chk("b_final_count", 32'(b_count), 32'd0);

    tick();
    chk("a_queue_empty", 32'(qa.size()), 32'd0);
    chk("b_queue_empty", 32'(qb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
